mem_port_arbiter: RTL and testbench

- Parametrised successor to the split instruction/data memory hookup: NUM_PORTS valid/good requesters share one backing memory port.
- Sits between CPU fetch/load-store ports (plus future DMA/debug masters) and a single unified memory.
- Arbitration is round-robin with one outstanding transaction.
- Requests and responses are registered.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_picker.sv | 37 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;

  // Read data returned when a backing transaction is abandoned by the timeout
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - round-robin winner search starting at rr_ptr
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic                 any_req,
  output logic [PTR_W-1:0]     winner
);

  logic [2*NUM_PORTS-1:0] masked;
  logic                   found;
  int                     idx;

  // Lower copy hides ports below rr_ptr; upper copy supplies the wrap-around
  always_comb begin
    masked = {req, req};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i < int'(rr_ptr)) masked[i] = 1'b0;
    end
  end

  always_comb begin
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = i;
      end
    end
    any_req = |req;
    winner  = (idx >= NUM_PORTS) ? PTR_W'(idx - NUM_PORTS) : PTR_W'(idx);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter of NUM_PORTS requesters onto one memory port
// Optional forced-error completion after TIMEOUT_CYCLES WAIT cycles: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]        req_memRead,
  input  logic [NUM_PORTS-1:0]        req_memWrite,
  input  logic [NUM_PORTS*2-1:0]      req_maskMode,
  input  logic [NUM_PORTS-1:0]        req_sext,
  output logic [NUM_PORTS-1:0]        req_good,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_err,
  output logic                        mem_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_writeData,
  output logic                        mem_memRead,
  output logic                        mem_memWrite,
  output logic [1:0]                  mem_maskMode,
  output logic                        mem_sext,
  input  logic                        mem_good,
  input  logic [DATA_W-1:0]           mem_readData
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state, state_next;
  logic [PTR_W-1:0]     rr_ptr, grant, winner;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 any_req, do_grant, do_finish;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rd, sel_wr, sel_sext;
  logic [1:0]        sel_mask;

  rr_picker #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_mask  = 2'd0;
    sel_sext  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_rd    = req_memRead[i];
        sel_wr    = req_memWrite[i];
        sel_mask  = req_maskMode[i*2 +: 2];
        sel_sext  = req_sext[i];
      end
    end
  end

  assign grant_onehot = NUM_PORTS'(1) << grant;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit, timed_out;

  // Counts completed WAIT cycles; the TIMEOUT_CYCLES-th WAIT cycle is the last one
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (do_grant) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_FILL};
  assign req_err = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_finish  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          do_grant   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_good) begin
          do_finish  = 1'b1;
          state_next = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          do_finish  = 1'b1;
          timed_out  = 1'b1;
          state_next = RESP;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      grant         <= '0;
      req_good      <= '0;
      req_rdata     <= '0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_writeData <= '0;
      mem_memRead   <= 1'b0;
      mem_memWrite  <= 1'b0;
      mem_maskMode  <= 2'd0;
      mem_sext      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      req_err       <= '0;
`endif
    end else begin
      req_good <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      req_err  <= '0;
`endif
      if (do_grant) begin
        grant         <= winner;
        rr_ptr        <= (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
        mem_valid     <= 1'b1;
        mem_addr      <= sel_addr;
        mem_writeData <= sel_wdata;
        mem_memRead   <= sel_rd;
        mem_memWrite  <= sel_wr;
        mem_maskMode  <= sel_mask;
        mem_sext      <= sel_sext;
      end
      if (do_finish) begin
        mem_valid <= 1'b0;
        req_good  <= grant_onehot;
        req_rdata <= mem_readData;
`ifdef MEM_ARB_TIMEOUT_EN
        if (timed_out) begin
          req_rdata <= DATA_W'(TIMEOUT_FILL);
          req_err   <= grant_onehot;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk, reset;
  logic [N-1:0]    req_valid, req_memRead, req_memWrite, req_sext;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*2-1:0]  req_maskMode;
  logic [N-1:0]    req_good, req_err;
  logic [DW-1:0]   req_rdata;
  logic            mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_good;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_writeData, mem_readData;
  logic [1:0]      mem_maskMode;
  logic [69:0]     mem_bus;

  assign mem_bus = {mem_valid, mem_addr, mem_writeData, mem_memRead, mem_memWrite, mem_maskMode, mem_sext};

  mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_memRead(req_memRead), .req_memWrite(req_memWrite),
    .req_maskMode(req_maskMode), .req_sext(req_sext),
    .req_good(req_good), .req_rdata(req_rdata), .req_err(req_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_maskMode(mem_maskMode), .mem_sext(mem_sext),
    .mem_good(mem_good), .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr, input logic [1:0] m, input logic s);
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
    req_memRead[p]         = rd;
    req_memWrite[p]        = wr;
    req_maskMode[p*2 +: 2] = m;
    req_sext[p]            = s;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One arbitration round with minimum memory latency; returns the RESP-cycle good vector
  task automatic serve_one(output logic [N-1:0] g);
    @(posedge clk); #1;
    mem_good     = 1'b1;
    mem_readData = 32'h0;
    @(posedge clk); #1;
    mem_good = 1'b0;
    g        = req_good;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic        sext;
    int          wait_cyc;
    logic [31:0] rdata_in;
    logic [3:0]  exp_good;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    logic [69:0]  exp_bus;

    vecs[0] = '{port:1, addr:32'h100, wdata:32'h0, rd:1'b1, wr:1'b0, mask:MASK_WORD, sext:1'b0,
                wait_cyc:2, rdata_in:32'h12345678, exp_good:4'b0010, exp_rdata:32'h12345678};
    vecs[1] = '{port:0, addr:32'h20, wdata:32'hCAFEF00D, rd:1'b0, wr:1'b1, mask:MASK_HALF, sext:1'b0,
                wait_cyc:4, rdata_in:32'h0, exp_good:4'b0001, exp_rdata:32'h0};
    vecs[2] = '{port:3, addr:32'h3FC, wdata:32'h0, rd:1'b1, wr:1'b0, mask:MASK_BYTE, sext:1'b1,
                wait_cyc:0, rdata_in:32'h000000A5, exp_good:4'b1000, exp_rdata:32'h000000A5};
    vecs[3] = '{port:2, addr:32'hFFFFFFF0, wdata:32'h0BADF00D, rd:1'b1, wr:1'b1, mask:MASK_WORD, sext:1'b0,
                wait_cyc:1, rdata_in:32'h5A5A5A5A, exp_good:4'b0100, exp_rdata:32'h5A5A5A5A};

    reset = 1'b1;
    req_valid = '0; req_memRead = '0; req_memWrite = '0; req_sext = '0;
    req_addr = '0; req_wdata = '0; req_maskMode = '0;
    mem_good = 1'b0; mem_readData = '0;

    #12;
    chk("reset_mem_bus", 128'(mem_bus), 128'h0);
    chk("reset_good", 128'(req_good), 128'h0);
    chk("reset_rdata", 128'(req_rdata), 128'h0);
    chk("reset_err", 128'(req_err), 128'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Spurious mem_good while IDLE
    mem_good = 1'b1;
    mem_readData = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_good = 1'b0;
    chk("spurious_good", 128'(req_good), 128'h0);
    chk("spurious_rdata", 128'(req_rdata), 128'h0);
    chk("spurious_mem_valid", 128'(mem_valid), 128'h0);
    @(posedge clk); #1;
    chk("spurious_good_late", 128'(req_good), 128'h0);

    // Ports 0 and 1 raise valid together right after reset
    set_port(0, 32'hA000, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    set_port(1, 32'hB000, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    req_valid = 4'b0011;
    serve_one(g);
    chk("contend_first", 128'(g), 128'h1);
    req_valid[0] = 1'b0;
    serve_one(g);
    chk("contend_second", 128'(g), 128'h2);
    req_valid = '0;

    for (int i = 0; i < 4; i++) begin
      set_port(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].sext);
      req_valid[vecs[i].port] = 1'b1;
      exp_bus = {1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].sext};
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant_bus", i), 128'(mem_bus), 128'(exp_bus));
      for (int w = 0; w < vecs[i].wait_cyc; w++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_wait%0d_bus", i, w), 128'(mem_bus), 128'(exp_bus));
        chk($sformatf("v%0d_wait%0d_good", i, w), 128'(req_good), 128'h0);
      end
      mem_good = 1'b1;
      mem_readData = vecs[i].rdata_in;
      @(posedge clk); #1;
      mem_good = 1'b0;
      req_valid[vecs[i].port] = 1'b0;
      chk($sformatf("v%0d_resp_good", i), 128'(req_good), 128'(vecs[i].exp_good));
      chk($sformatf("v%0d_resp_rdata", i), 128'(req_rdata), 128'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_resp_err", i), 128'(req_err), 128'h0);
      chk($sformatf("v%0d_resp_mem_valid", i), 128'(mem_valid), 128'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_good", i), 128'(req_good), 128'h0);
      chk($sformatf("v%0d_idle_rdata_hold", i), 128'(req_rdata), 128'(vecs[i].exp_rdata));
    end

    // Fairness: all four ports request continuously from a fresh reset
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 32'h1000 + p, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve_one(g);
      chk($sformatf("fair_grant%0d", k), 128'(g), 128'(4'b0001 << (k % N)));
    end
    req_valid = '0;

    // Asynchronous reset in the middle of WAIT
    set_port(2, 32'hC200, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    set_port(3, 32'hC300, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    req_valid = 4'b1100;
    @(posedge clk); #1;
    chk("abort_grant_addr", 128'(mem_addr), 128'h0000C200);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_valid", 128'(mem_valid), 128'h0);
    chk("abort_good", 128'(req_good), 128'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("regrant_addr", 128'(mem_addr), 128'h0000C200);
    chk("regrant_mem_valid", 128'(mem_valid), 128'h1);
    chk("regrant_no_good", 128'(req_good), 128'h0);
    mem_good = 1'b1;
    mem_readData = 32'h77;
    @(posedge clk); #1;
    mem_good = 1'b0;
    req_valid = '0;
    chk("regrant_resp_good", 128'(req_good), 128'h4);
    @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    set_port(0, 32'h40, 32'h0, 1'b1, 1'b0, MASK_WORD, 1'b0);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    repeat (7) begin @(posedge clk); #1; end
    chk("to_not_yet_good", 128'(req_good), 128'h0);
    chk("to_not_yet_valid", 128'(mem_valid), 128'h1);
    @(posedge clk); #1;
    req_valid = '0;
    chk("to_good", 128'(req_good), 128'h1);
    chk("to_err", 128'(req_err), 128'h1);
    chk("to_rdata", 128'(req_rdata), 128'(TIMEOUT_FILL));
    chk("to_mem_valid", 128'(mem_valid), 128'h0);
    @(posedge clk); #1;

    req_valid = 4'b0001;
    @(posedge clk); #1;
    repeat (7) begin @(posedge clk); #1; end
    mem_good = 1'b1;
    mem_readData = 32'h11223344;
    @(posedge clk); #1;
    mem_good = 1'b0;
    req_valid = '0;
    chk("to_race_good", 128'(req_good), 128'h1);
    chk("to_race_err", 128'(req_err), 128'h0);
    chk("to_race_rdata", 128'(req_rdata), 128'h11223344);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
